// File: rtl/adiabatic_inv_pipe.sv
// adiabatic_inv_pipe: multi-stage adiabatic inverter chain driven by a
// four-phase power-clock sequencer. Each stage evaluates on its own phase and
// recovers (clears) on the following phase, so a word ripples down the chain
// one stage per phase with a valid flag alongside it.
//
// Power-clock phase FSM:
//   state | meaning
//   PH0   | stages 0,4,8.. evaluate; stage 0 samples din (in_ready on tick)
//   PH1   | stages 1,5,9.. evaluate; stages 0,4,8.. recover
//   PH2   | stages 2,6,..  evaluate; stages 1,5,..  recover
//   PH3   | stages 3,7,..  evaluate; stages 2,6,..  recover
module adiabatic_inv_pipe #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 4,
    parameter int PHASE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    output logic [3:0]       pwr_phase,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic [15:0]      out_cnt
);
    localparam int               SUB_W    = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_CYC - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t           ph_q;
    phase_t           ph_d;
    logic [SUB_W-1:0] sub_q;
    logic             tick;
    logic [15:0]      cnt_q;
    logic             last_eval;
    logic             last_nv;

    // A tick ends a phase; en low suppresses it even on the terminal sub count.
    assign tick = en && (sub_q == SUB_LAST);

    // Sub-phase counter: counts enabled cycles within one power-clock phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= '0;
        end else if (en) begin
            sub_q <= tick ? '0 : sub_q + SUB_ONE;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q <= PH0;
        end else begin
            ph_q <= ph_d;
        end
    end

    // Phase advance on tick; stage 0 is open for a new word only on the PH0 tick.
    always_comb begin
        ph_d     = ph_q;
        in_ready = 1'b0;
        if (tick) begin
            in_ready = (ph_q == PH0);
            case (ph_q)
                PH0: ph_d = PH1;
                PH1: ph_d = PH2;
                PH2: ph_d = PH3;
                PH3: ph_d = PH0;
            endcase
        end
    end

    // Phase stays visible while frozen by en low.
    assign pwr_phase = 4'b0001 << ph_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [1:0] EV_PH = 2'(k % 4);
        localparam logic [1:0] RC_PH = 2'((k + 1) % 4);

        logic [WIDTH-1:0] s;
        logic             v;
        logic [WIDTH-1:0] nd;
        logic             nv;
        logic             eval_k;
        logic             rec_k;

        if (k == 0) begin : g_in
            assign nd = ~din;
            assign nv = in_valid;
        end else begin : g_chain
            assign nd = ~g_stage[k-1].s;
            assign nv = g_stage[k-1].v;
        end

        assign eval_k = tick && (ph_q == phase_t'(EV_PH));
        assign rec_k  = tick && (ph_q == phase_t'(RC_PH));

        // Evaluate captures the inverted upstream word (bubbles load zero);
        // recover returns the stage to zero one phase later.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s <= '0;
                v <= 1'b0;
            end else if (eval_k) begin
                s <= nv ? nd : '0;
                v <= nv;
            end else if (rec_k) begin
                s <= '0;
                v <= 1'b0;
            end
        end
    end

    assign dout      = g_stage[STAGES-1].s;
    assign out_valid = g_stage[STAGES-1].v;
    assign last_eval = g_stage[STAGES-1].eval_k;
    assign last_nv   = g_stage[STAGES-1].nv;

    // Delivered-word counter, held at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (last_eval && last_nv && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign out_cnt = cnt_q;

endmodule

// File: tb/tb_adiabatic_inv_pipe.sv
// Testbench for adiabatic_inv_pipe (WIDTH=8, STAGES=5, PHASE_CYC=2).
// Words are injected from a vector table at successive in_ready slots; a
// scoreboard queue holds each expected output word and the enabled-cycle
// index at which it must appear, and every cycle the outputs are compared.
module tb_adiabatic_inv_pipe;
    localparam int WIDTH  = 8;
    localparam int STAGES = 5;
    localparam int PC     = 2;
    localparam int LAT    = (STAGES - 1) * PC;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             in_ready;
    logic [3:0]       pwr_phase;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic [15:0]      out_cnt;

    always #5 clk = ~clk;

    adiabatic_inv_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .PHASE_CYC(PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .pwr_phase (pwr_phase),
        .dout      (dout),
        .out_valid (out_valid),
        .out_cnt   (out_cnt)
    );

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         counted;
    } sb_t;

    vec_t        vecs[6];
    sb_t         sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          ecyc;
    logic [15:0] exp_cnt;
    logic [7:0]  drv_exp;
    bit          saw_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, then return just after
    // the next rising edge so the caller can drive inputs.
    task automatic cyc();
        logic       exp_v;
        logic [7:0] exp_d;
        @(negedge clk);
        saw_rdy = 1'b0;
        if (rst) begin
            sb.delete();
            ecyc    = 0;
            exp_cnt = '0;
        end else begin
            exp_v = 1'b0;
            exp_d = '0;
            if (sb.size() > 0 && ecyc >= sb[0].due && ecyc < sb[0].due + PC) begin
                exp_v = 1'b1;
                exp_d = sb[0].data;
                if (!sb[0].counted) begin
                    sb[0].counted = 1'b1;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("dout", 32'(dout), 32'(exp_d));
            chk("out_cnt", 32'(out_cnt), 32'(exp_cnt));
            chk("pwr_phase", 32'(pwr_phase), 32'(4'b0001 << ((ecyc / PC) % 4)));
            chk("in_ready", 32'(in_ready), 32'(en && ((ecyc % (4 * PC)) == PC - 1)));
            saw_rdy = in_ready;
            if (in_ready && in_valid)
                sb.push_back('{data: drv_exp, due: ecyc + 1 + LAT, counted: 1'b0});
            if (exp_v && en && ecyc == sb[0].due + PC - 1)
                void'(sb.pop_front());
            if (en) ecyc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the next in_ready slot takes it.
    task automatic inject(input logic [7:0] d, input logic vld, input logic [7:0] e);
        din      = d;
        in_valid = vld;
        drv_exp  = e;
        for (int i = 0; i < 4 * PC + 2; i++) begin
            cyc();
            if (saw_rdy) break;
        end
        chk("inject_slot", 32'(saw_rdy), 32'd1);
        in_valid = 1'b0;
        din      = 8'($urandom);
    endtask

    initial begin
        vecs[0] = '{din: 8'h3C, vld: 1'b1, exp: 8'hC3};
        vecs[1] = '{din: 8'hA5, vld: 1'b1, exp: 8'h5A};
        vecs[2] = '{din: 8'h5A, vld: 1'b1, exp: 8'hA5};
        vecs[3] = '{din: 8'hFF, vld: 1'b0, exp: 8'h00};
        vecs[4] = '{din: 8'h00, vld: 1'b1, exp: 8'hFF};
        vecs[5] = '{din: 8'h81, vld: 1'b1, exp: 8'h7E};

        rst = 1'b0; en = 1'b0; in_valid = 1'b0; din = '0;
        drv_exp = '0; ecyc = 0; exp_cnt = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_pwr_phase", 32'(pwr_phase), 32'h1);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_cnt", 32'(out_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);

        en = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        foreach (vecs[i]) inject(vecs[i].din, vecs[i].vld, vecs[i].exp);
        repeat (20) cyc();

        // Freeze the sequencer for 7 cycles starting on a would-be tick.
        inject(8'h11, 1'b1, 8'hEE);
        cyc();
        en = 1'b0;
        repeat (7) cyc();
        en = 1'b1;
        repeat (20) cyc();

        // Two words in flight, then an asynchronous reset between edges.
        inject(8'h3C, 1'b1, 8'hC3);
        inject(8'h96, 1'b1, 8'h69);
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_out_cnt", 32'(out_cnt), 32'h0);
        chk("arst_pwr_phase", 32'(pwr_phase), 32'h1);
        cyc();
        cyc();
        rst = 1'b0;

        // Counter saturation: start just below all-ones and stream past it.
        force dut.cnt_q = 16'hFFFC;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFC;
        for (int i = 0; i < 6; i++) inject(8'(i * 37 + 1), 1'b1, ~8'(i * 37 + 1));
        repeat (20) cyc();
        chk("out_cnt_saturated", 32'(out_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
